bram_dp: RTL

Parametrised simple dual-port block RAM: one write port with byte enables, one read port, a shared rising-edge clock and a built-in memory-clear sequencer. It is the successor to the team's fixed 256×32 single-port cache store and is instantiated wherever a cache, FIFO backing store or lookup table needs concurrent read and write. Contents are zeroed by hardware after reset and on request, so no simulation-only initialisation is relied upon.

---
 rtl/bram_dp.sv | 130 +++++++++++++
 1 files changed

// File: rtl/bram_dp.sv
// Simple dual-port block RAM with byte-enable writes, one read port and a hardware
// clear sweep. Define BRAM_DP_OUT_REG_EN to add an output register stage (latency 2).
module bram_dp #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 256,
  parameter int WRITE_FIRST = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_req,
  output logic                busy,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid
);

  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t              state, state_d;
  logic [ADDR_W-1:0]   clr_ptr, clr_ptr_d;
  logic                clr_we;
  logic                wr_in, rd_in;
  logic                wr_act, rd_act;
  logic [DATA_W-1:0]   ram [DEPTH];
  logic [DATA_W-1:0]   rd_word;
  logic [DATA_W-1:0]   rd_q;
  logic                rd_v_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_d;
      clr_ptr <= clr_ptr_d;
    end
  end

  always_comb begin
    state_d   = state;
    clr_ptr_d = clr_ptr;
    clr_we    = 1'b0;
    case (state)
      CLEAR: begin
        clr_we    = !rst;
        clr_ptr_d = clr_ptr + 1'b1;
        if (clr_ptr == LAST) state_d = IDLE;
      end
      IDLE: begin
        if (clr_req) begin
          state_d   = CLEAR;
          clr_ptr_d = '0;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  assign busy   = (state == CLEAR);
  assign wr_in  = ({1'b0, wr_addr} < DEPTH_X);
  assign rd_in  = ({1'b0, rd_addr} < DEPTH_X);
  assign wr_act = (state == IDLE) && !clr_req && wr_en && wr_in;
  assign rd_act = (state == IDLE) && !clr_req && rd_en;

  always_ff @(posedge clk) begin
    if (clr_we) begin
      ram[clr_ptr] <= '0;
    end else if (wr_act) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (wr_be[i]) ram[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // Write-first bypass merges the enabled bytes of a same-address write into the read word.
  always_comb begin
    rd_word = '0;
    if (rd_in) rd_word = ram[rd_addr];
    if ((WRITE_FIRST != 0) && wr_act && (wr_addr == rd_addr)) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (wr_be[i]) rd_word[8*i +: 8] = wr_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q   <= '0;
      rd_v_q <= 1'b0;
    end else begin
      rd_v_q <= rd_act;
      if (rd_act) rd_q <= rd_word;
    end
  end

`ifdef BRAM_DP_OUT_REG_EN
  logic [DATA_W-1:0] rd_q2;
  logic              rd_v_q2;

  // Entering CLEAR flushes a read still in flight in the first stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q2   <= '0;
      rd_v_q2 <= 1'b0;
    end else if (state == IDLE && state_d == CLEAR) begin
      rd_v_q2 <= 1'b0;
    end else begin
      rd_v_q2 <= rd_v_q;
      if (rd_v_q) rd_q2 <= rd_q;
    end
  end

  assign rd_data  = rd_q2;
  assign rd_valid = rd_v_q2;
`else
  assign rd_data  = rd_q;
  assign rd_valid = rd_v_q;
`endif

endmodule
